down_count_timer: RTL and testbench
===================================

# down_count_timer

Loadable, enable-gated synchronous down counter with a one-cycle `done` pulse on terminal count. It counts in the opposite direction to the team's ripple up-counter built from `D_FF`/`T_FF` cells, and provides timeouts and event spacing. It sits beside the up-counter in the Chapter 2 design hierarchy and is fully synchronous: one clock edge, no ripple.

## Interface
- `WIDTH`, default 4: counter and load-value width in bits (≥ 2).
- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: **synchronous, active-high reset**.
- `load` input 1: load request; samples `load_value` on the clock edge.
- `load_value` input WIDTH: start value for the countdown.
- `en` input 1: count enable; decrements by 1 per enabled edge while running.
- `count` output WIDTH: current counter value, registered.
- `busy` output 1: high while in state RUN.
- `zero` output 1: high when `count == 0`; decoded from the register.
- `done` output 1: registered one-cycle pulse on reaching terminal count.

## Operation
- State machine:
  - IDLE: not counting, `count` holds.
  - RUN: counting down.
  - DONE: terminal count reached, `count == 0`.
- Reset values: `count = 0`, reload register = 0, state IDLE, `busy = 0`, `done = 0`, `zero = 1`.
- Priority when signals coincide: `reset` > `load` > `en`.
- `load = 1`, in any state:
  - `count <= load_value`.
  - Reload register `<= load_value`.
  - `load_value != 0` → next state RUN.
  - `load_value == 0` → next state IDLE, with no `done` pulse.
- RUN with `en = 1`, `load = 0`:
  - `count > 1`: `count <= count - 1`.
  - `count == 1`: terminal event. `done <= 1` for exactly one cycle; the next-state behaviour depends on configuration (see below).
- RUN with `en = 0`: `count` and state hold. Pausing is unlimited.
- IDLE and DONE: `en` is ignored. Only `load` leaves these states.
- `done` is 0 in every cycle that does not follow a terminal event.
- Arithmetic is unsigned modulo 2^WIDTH. Underflow is impossible by construction, because decrement happens only for `count ≥ 1`.
- `load_value = 2^WIDTH - 1` is legal and gives the maximum period.
- `load` asserted in the same cycle as a terminal event:
  - `load` wins; `count <= load_value`.
  - `done` is still pulsed, because the terminal count was reached.
- `reset` mid-run: all registers return to reset values on that edge. Any pending `done` is suppressed.

## Timing
- Load latency: `load` sampled at edge k → `count = load_value` and `busy = 1` after edge k.
- Countdown length: for a loaded value N and continuous `en`, the Nth enabled edge after the load is the terminal edge.
  - After that edge: `done = 1` for one cycle.
  - Without auto-reload: `count = 0`, `zero = 1`, `busy = 0`.
- `count`, `busy` and `done` are registered.
- `zero` is a combinational decode of the `count` register only; it has no input-to-output path.

## Configuration
- Macro: `DOWN_COUNT_TIMER_AUTO_RELOAD_EN`.
- Not defined (one-shot mode), on the terminal edge:
  - `count <= 0`, next state DONE, `busy` drops.
  - The counter stays in DONE until `load`.
- Defined (periodic mode), on the terminal edge:
  - `count <=` reload register, and the state stays RUN.
  - `done` pulses once every N enabled cycles indefinitely.
  - In periodic mode `count` never shows 0 while running. DONE is unreachable and `zero` is high only in IDLE.

## Test plan
All scenarios use WIDTH = 4.
- **Reset:** assert `reset` for 2 cycles with `load = 1` and `load_value = 5` → `count = 0`, `busy = 0`, `zero = 1`, `done = 0` throughout. Deassert → stays IDLE.
- **One-shot countdown:** load 3, then `en = 1` continuously → `count` reads 3, 2, 1, 0. `done = 1` only in the cycle `count` first reads 0, then `busy = 0`. Further `en` pulses leave `count = 0`.
- **Pause:** load 4; sequence `en = 1, 0, 0, 1, 1, 1` → `count` reads 4, 3, 3, 3, 2, 1, 0. `done` appears once, after the 4th enabled edge.
- **Zero and max load:**
  - Load 0 → IDLE, `done` never pulses, `busy = 0`.
  - Load 15 with `en = 1` → `done` after exactly 15 edges.
- **Collision:** load 2 and run to the terminal edge, asserting `load = 1` with `load_value = 7` on that edge → `done = 1` for one cycle, `count = 7`, `busy = 1`.
- **Auto-reload** (macro defined): load 3 with `en = 1` for 9 cycles → `count` reads 3, 2, 1, 3, 2, 1, 3, 2, 1. `done` pulses after edges 3, 6 and 9. `busy` stays 1.

Source files
------------

// File: rtl/down_count_timer_if.sv
// down_count_timer_if: control and status bundle for down_count_timer.
//   load       : load request, sampled with load_value on the rising edge
//   load_value : countdown start value (WIDTH bits)
//   en         : count enable
//   count      : current counter value (registered)
//   busy       : high while counting
//   zero       : high when count == 0 (decoded from the count register)
//   done       : one-cycle pulse after the terminal edge
// The master modport is the controlling side. The slave modport is the timer.
interface down_count_timer_if #(
  parameter int WIDTH = 4
);
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             en;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             zero;
  logic             done;

  modport master (
    output load, load_value, en,
    input  count, busy, zero, done
  );

  modport slave (
    input  load, load_value, en,
    output count, busy, zero, done
  );
endinterface

// File: rtl/down_count_timer.sv
// down_count_timer: loadable, enable-gated synchronous down counter.
// It drives a one-cycle done pulse when the count reaches its terminal value.
//
// Ports:
//   clk   : clock. All state changes on the rising edge.
//   reset : synchronous, active-high reset.
//   bus   : down_count_timer_if.slave carrying load, load_value, en,
//           count, busy, zero and done.
//
// Build option:
//   DOWN_COUNT_TIMER_AUTO_RELOAD_EN
//     undefined : one-shot mode. The terminal edge clears count and the
//                 timer parks in DONE until the next load.
//     defined   : periodic mode. The terminal edge restores the last loaded
//                 value and the timer stays in RUN.
module down_count_timer #(
  parameter int WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  down_count_timer_if.slave     bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]       state_reg,  state_next;
  logic [WIDTH-1:0] count_reg,  count_next;
  logic [WIDTH-1:0] reload_reg, reload_next;
  logic             done_reg,   done_next;
  logic             terminal;

  // The terminal edge is an enabled edge in RUN with count at 1. A load on
  // the same edge still lets the pulse through.
  assign terminal = (state_reg == RUN) && bus.en && (count_reg == ONE);

  always_comb begin
    state_next  = state_reg;
    count_next  = count_reg;
    reload_next = reload_reg;
    done_next   = terminal;

    if (bus.load) begin
      count_next  = bus.load_value;
      reload_next = bus.load_value;
      state_next  = (bus.load_value != '0) ? RUN : IDLE;
    end else if ((state_reg == RUN) && bus.en) begin
      if (terminal) begin
`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
        count_next = reload_reg;
        state_next = RUN;
`else
        count_next = '0;
        state_next = DONE;
`endif
      end else begin
        count_next = count_reg - ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      reload_reg <= '0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      count_reg  <= count_next;
      reload_reg <= reload_next;
      done_reg   <= done_next;
    end
  end

  assign bus.count = count_reg;
  assign bus.busy  = (state_reg == RUN);
  assign bus.zero  = (count_reg == '0);
  assign bus.done  = done_reg;

endmodule

// File: tb/tb_down_count_timer.sv
module tb_down_count_timer;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  down_count_timer_if #(.WIDTH(4)) bus ();

  down_count_timer #(.WIDTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  // Advance one rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input int c, input int b, input int z, input int d);
    check({tag, ".count"}, 32'(bus.count), c);
    check({tag, ".busy"},  32'(bus.busy),  b);
    check({tag, ".zero"},  32'(bus.zero),  z);
    check({tag, ".done"},  32'(bus.done),  d);
  endtask

  task automatic drive(input logic l, input logic [3:0] v, input logic e);
    bus.load       = l;
    bus.load_value = v;
    bus.en         = e;
  endtask

  initial begin
    drive(1'b0, 4'd0, 1'b0);

    // Reset wins over load.
    reset = 1'b1;
    drive(1'b1, 4'd5, 1'b0);
    tick(); expect_all("rst1", 0, 0, 1, 0);
    tick(); expect_all("rst2", 0, 0, 1, 0);
    reset = 1'b0;
    drive(1'b0, 4'd5, 1'b1);
    tick(); expect_all("rst_idle", 0, 0, 1, 0);

    // Load 0: back to IDLE, no done pulse, en ignored.
    drive(1'b1, 4'd0, 1'b1);
    tick(); expect_all("load0", 0, 0, 1, 0);
    drive(1'b0, 4'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(); expect_all($sformatf("load0_en%0d", i), 0, 0, 1, 0);
    end

    // Collision: load on the terminal edge still pulses done.
    drive(1'b1, 4'd2, 1'b1);
    tick(); expect_all("col_load", 2, 1, 0, 0);
    drive(1'b0, 4'd0, 1'b1);
    tick(); expect_all("col_1", 1, 1, 0, 0);
    drive(1'b1, 4'd7, 1'b1);
    tick(); expect_all("col_term", 7, 1, 0, 1);
    drive(1'b0, 4'd0, 1'b0);
    tick(); expect_all("col_after", 7, 1, 0, 0);

    // Reset on a terminal edge suppresses done.
    drive(1'b1, 4'd1, 1'b1);
    tick(); expect_all("rstrun_load", 1, 1, 0, 0);
    drive(1'b0, 4'd0, 1'b1);
    reset = 1'b1;
    tick(); expect_all("rstrun", 0, 0, 1, 0);
    reset = 1'b0;
    tick(); expect_all("rstrun_after", 0, 0, 1, 0);

`ifdef DOWN_COUNT_TIMER_AUTO_RELOAD_EN
    // Periodic: 3,2,1,3,2,1,... with done after edges 3, 6, 9.
    drive(1'b1, 4'd3, 1'b1);
    tick(); expect_all("ar_load", 3, 1, 0, 0);
    drive(1'b0, 4'd0, 1'b1);
    for (int i = 1; i <= 9; i++) begin
      tick();
      expect_all($sformatf("ar_e%0d", i), 3 - (i % 3), 1, 0, (i % 3 == 0) ? 1 : 0);
    end
`else
    // One-shot countdown from 3.
    drive(1'b1, 4'd3, 1'b1);
    tick(); expect_all("os_load", 3, 1, 0, 0);
    drive(1'b0, 4'd0, 1'b1);
    tick(); expect_all("os_2", 2, 1, 0, 0);
    tick(); expect_all("os_1", 1, 1, 0, 0);
    tick(); expect_all("os_0", 0, 0, 1, 1);
    tick(); expect_all("os_hold1", 0, 0, 1, 0);
    tick(); expect_all("os_hold2", 0, 0, 1, 0);

    // Pause: en = 1,0,0,1,1,1 from 4.
    drive(1'b1, 4'd4, 1'b0);
    tick(); expect_all("p_load", 4, 1, 0, 0);
    drive(1'b0, 4'd0, 1'b1); tick(); expect_all("p_e1", 3, 1, 0, 0);
    drive(1'b0, 4'd0, 1'b0); tick(); expect_all("p_h1", 3, 1, 0, 0);
    drive(1'b0, 4'd0, 1'b0); tick(); expect_all("p_h2", 3, 1, 0, 0);
    drive(1'b0, 4'd0, 1'b1); tick(); expect_all("p_e2", 2, 1, 0, 0);
    tick(); expect_all("p_e3", 1, 1, 0, 0);
    tick(); expect_all("p_e4", 0, 0, 1, 1);
    tick(); expect_all("p_after", 0, 0, 1, 0);

    // Maximum load: done after exactly 15 enabled edges.
    drive(1'b1, 4'd15, 1'b1);
    tick(); expect_all("max_load", 15, 1, 0, 0);
    drive(1'b0, 4'd0, 1'b1);
    for (int i = 1; i <= 15; i++) begin
      tick();
      expect_all($sformatf("max_e%0d", i), 15 - i, (i < 15) ? 1 : 0,
                 (i == 15) ? 1 : 0, (i == 15) ? 1 : 0);
    end
    tick(); expect_all("max_after", 0, 0, 1, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
